// File: rtl/vrf_addr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : vrf_addr_sequencer
//  Description : Per-lane sequencer for one address_counter. It accepts a
//                vector-register access command, loads the counter, steps it
//                element by element, flags the last element and reports
//                completion (error-qualified for illegal element widths).
//                Optional build macro VRF_ADDR_SEQ_STALL_EN: honour the
//                downstream ready_i backpressure. When undefined, ready_i is
//                ignored and every RUN cycle advances one element.
//  Revision    : 1.0 - initial release
// ============================================================================
module vrf_addr_sequencer #(
    parameter int MEM_DEPTH         = 512,
    parameter int VREG_LOC_PER_LANE = 8,
    parameter int VLANE_NUM         = 8,
    localparam int AW               = $clog2(MEM_DEPTH),
    localparam int CW               = $clog2(VREG_LOC_PER_LANE*4) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [1:0]    sew_i,
    input  logic          dir_i,
    input  logic [CW-1:0] elem_cnt_i,
    input  logic [AW-1:0] slide_offset_i,
    input  logic          abort_i,
    input  logic          ready_i,
    output logic          ready_o,
    output logic          load_o,
    output logic          rst_cnt_o,
    output logic          en_o,
    output logic          secondary_en_o,
    output logic          up_down_o,
    output logic [1:0]    element_width_o,
    output logic [AW-1:0] slide_offset_o,
    output logic          valid_o,
    output logic          last_o,
    output logic          done_o,
    output logic          error_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Lane count is informational only; reject nonsensical configurations.
    generate
        if (VLANE_NUM < 1) begin : g_lane_chk
            $error("VLANE_NUM must be at least 1");
        end
    endgenerate

    state_t        state_q, state_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [1:0]    sew_q, sew_d;
    logic          dir_q, dir_d;
    logic [AW-1:0] offset_q, offset_d;
    logic          err_q, err_d;

    logic [CW-1:0] w_limit;
    logic [CW-1:0] w_clamped;
    logic          w_hs;

    // Per-width element limit; the illegal width gets 0 so nothing is counted.
    always_comb begin
        w_limit = '0;
        case (sew_i)
            2'b00:   w_limit = CW'(VREG_LOC_PER_LANE*4);
            2'b01:   w_limit = CW'(VREG_LOC_PER_LANE*2);
            2'b10:   w_limit = CW'(VREG_LOC_PER_LANE);
            default: w_limit = '0;
        endcase
        w_clamped = (elem_cnt_i < w_limit) ? elem_cnt_i : w_limit;
    end

`ifdef VRF_ADDR_SEQ_STALL_EN
    assign w_hs           = ready_i;
    assign secondary_en_o = (state_q == ST_RUN) && ready_i;
`else
    // Without backpressure every RUN cycle is an element transfer.
    logic w_unused_ready;
    assign w_unused_ready = ready_i;
    assign w_hs           = 1'b1;
    assign secondary_en_o = 1'b1;
`endif

    // State and command registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            rem_q    <= '0;
            sew_q    <= '0;
            dir_q    <= 1'b0;
            offset_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            sew_q    <= sew_d;
            dir_q    <= dir_d;
            offset_q <= offset_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic; abort overrides everything, including a new command.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        sew_d    = sew_q;
        dir_d    = dir_q;
        offset_d = offset_q;
        err_d    = err_q;
        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        sew_d    = sew_i;
                        dir_d    = dir_i;
                        offset_d = slide_offset_i;
                        rem_d    = w_clamped;
                        err_d    = (sew_i == 2'b11);
                        if (sew_i == 2'b11 || w_clamped == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end
                end
                ST_LOAD: state_d = ST_RUN;
                ST_RUN: begin
                    // rem is at least 1 in RUN, so this never underflows.
                    if (w_hs) begin
                        rem_d = rem_q - CW'(1);
                        if (rem_q == CW'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Moore control outputs with the combinational abort overrides.
    always_comb begin
        ready_o   = (state_q == ST_IDLE);
        load_o    = (state_q == ST_LOAD) && !abort_i;
        rst_cnt_o = (state_q == ST_LOAD) || abort_i;
        en_o      = (state_q == ST_RUN) && !abort_i;
        valid_o   = (state_q == ST_RUN) && !abort_i;
        last_o    = (state_q == ST_RUN) && (rem_q == CW'(1));
        done_o    = (state_q == ST_DONE);
        error_o   = (state_q == ST_DONE) && err_q;
    end

    assign up_down_o       = dir_q;
    assign element_width_o = sew_q;
    assign slide_offset_o  = offset_q;

endmodule
`default_nettype wire

// File: tb/tb_vrf_addr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vrf_addr_sequencer
//  Description : Directed self-checking bench for vrf_addr_sequencer. The
//                stall scenario is selected by VRF_ADDR_SEQ_STALL_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vrf_addr_sequencer;

    localparam int AW = 9;
    localparam int CW = 6;
`ifdef VRF_ADDR_SEQ_STALL_EN
    localparam bit SEC_IDLE = 1'b0;
`else
    localparam bit SEC_IDLE = 1'b1;
`endif

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic          start_i = 1'b0;
    logic [1:0]    sew_i = '0;
    logic          dir_i = 1'b0;
    logic [CW-1:0] elem_cnt_i = '0;
    logic [AW-1:0] slide_offset_i = '0;
    logic          abort_i = 1'b0;
    logic          ready_i = 1'b1;
    logic          ready_o, load_o, rst_cnt_o, en_o, secondary_en_o, up_down_o;
    logic [1:0]    element_width_o;
    logic [AW-1:0] slide_offset_o;
    logic          valid_o, last_o, done_o, error_o;

    int checks = 0;
    int errors = 0;

    vrf_addr_sequencer #(
        .MEM_DEPTH(512),
        .VREG_LOC_PER_LANE(8),
        .VLANE_NUM(8)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .sew_i(sew_i),
        .dir_i(dir_i), .elem_cnt_i(elem_cnt_i), .slide_offset_i(slide_offset_i),
        .abort_i(abort_i), .ready_i(ready_i), .ready_o(ready_o), .load_o(load_o),
        .rst_cnt_o(rst_cnt_o), .en_o(en_o), .secondary_en_o(secondary_en_o),
        .up_down_o(up_down_o), .element_width_o(element_width_o),
        .slide_offset_o(slide_offset_o), .valid_o(valid_o), .last_o(last_o),
        .done_o(done_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    // Move to 1 time unit past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [14:0] got, exp;
        rst_i = 1'b0;
        repeat (3) tick();
        #1;
        got = {ready_o, load_o, rst_cnt_o, en_o, secondary_en_o, valid_o, last_o,
               done_o, error_o, up_down_o, element_width_o, slide_offset_o[2:0]};
        exp = {1'b1, 1'b0, 1'b0, 1'b0, SEC_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_outputs got %b exp %b", got, exp);
        end
        checks++;
        if (slide_offset_o !== '0) begin
            errors++;
            $display("FAIL reset_offset got %h exp 0", slide_offset_o);
        end
        rst_i = 1'b1;
        tick();
    endtask

    task automatic test_word_no_stall();
        logic [5:0]  got, exp;
        logic [11:0] gl, el;
        sew_i = 2'b10; elem_cnt_i = 6'd8; dir_i = 1'b1;
        slide_offset_i = 9'h1A5; ready_i = 1'b1; start_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL word_ready_c0 got %b exp 1", ready_o);
        end
        for (int c = 1; c <= 12; c++) begin
            tick();
            start_i = 1'b0;
            #1;
            got = {ready_o, load_o, valid_o, last_o, done_o, error_o};
            exp = {c >= 11, c == 1, (c >= 2 && c <= 9), c == 9, c == 10, 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL word_seq c=%0d got %b exp %b", c, got, exp);
            end
            gl = {up_down_o, element_width_o, slide_offset_o};
            el = {1'b1, 2'b10, 9'h1A5};
            checks++;
            if (gl !== el) begin
                errors++;
                $display("FAIL word_latched c=%0d got %h exp %h", c, gl, el);
            end
        end
    endtask

`ifdef VRF_ADDR_SEQ_STALL_EN
    task automatic test_byte_stall();
        logic [5:0] got, exp;
        logic       rdy;
        int         hs = 0;
        sew_i = 2'b00; elem_cnt_i = 6'd40; dir_i = 1'b0;
        slide_offset_i = 9'h004; ready_i = 1'b1; start_i = 1'b1;
        for (int c = 1; c <= 38; c++) begin
            tick();
            start_i = 1'b0;
            rdy = !(c == 3 || c == 4);
            ready_i = rdy;
            #1;
            got = {ready_o, load_o, valid_o, last_o, done_o, secondary_en_o};
            exp = {c >= 37, c == 1, (c >= 2 && c <= 35), c == 35, c == 36,
                   (c >= 2 && c <= 35) && rdy};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL byte_stall_seq c=%0d got %b exp %b", c, got, exp);
            end
            if (valid_o && ready_i) begin
                hs++;
                if (last_o) begin
                    checks++;
                    if (hs !== 32) begin
                        errors++;
                        $display("FAIL byte_last_handshake got %0d exp 32", hs);
                    end
                end
            end
        end
        ready_i = 1'b1;
        checks++;
        if (hs !== 32) begin
            errors++;
            $display("FAIL byte_handshakes got %0d exp 32", hs);
        end
    endtask
`else
    task automatic test_no_stall_macro();
        logic [5:0] got, exp;
        sew_i = 2'b10; elem_cnt_i = 6'd4; dir_i = 1'b1;
        slide_offset_i = 9'h010; start_i = 1'b1; ready_i = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            start_i = 1'b0;
            #1;
            got = {ready_o, load_o, valid_o, last_o, done_o, secondary_en_o};
            exp = {c >= 7, c == 1, (c >= 2 && c <= 5), c == 5, c == 6, 1'b1};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL nostall_seq c=%0d got %b exp %b", c, got, exp);
            end
        end
        ready_i = 1'b1;
    endtask
`endif

    task automatic test_illegal_zero();
        logic [3:0] got, exp;
        // Illegal element width.
        sew_i = 2'b11; elem_cnt_i = 6'd5; start_i = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            tick();
            start_i = 1'b0;
            #1;
            got = {ready_o, load_o, done_o, error_o};
            exp = {c == 2, 1'b0, c == 1, c == 1};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL illegal_sew c=%0d got %b exp %b", c, got, exp);
            end
        end
        // Zero count with a legal width.
        sew_i = 2'b01; elem_cnt_i = 6'd0; start_i = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            tick();
            start_i = 1'b0;
            #1;
            got = {ready_o, load_o, done_o, error_o};
            exp = {c == 2, 1'b0, c == 1, 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL zero_count c=%0d got %b exp %b", c, got, exp);
            end
        end
    endtask

    task automatic test_abort();
        logic [4:0] got, exp;
        sew_i = 2'b01; elem_cnt_i = 6'd8; dir_i = 1'b1; ready_i = 1'b1;
        slide_offset_i = 9'h077; start_i = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            start_i = 1'b0;
            abort_i = (c == 4);
            #1;
            got = {ready_o, rst_cnt_o, valid_o, en_o, done_o};
            exp = {c >= 5, (c == 1 || c == 4), (c == 2 || c == 3), (c == 2 || c == 3), 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL abort_seq c=%0d got %b exp %b", c, got, exp);
            end
        end
        // Abort together with start in IDLE drops the command.
        start_i = 1'b1; abort_i = 1'b1; elem_cnt_i = 6'd3;
        for (int c = 1; c <= 3; c++) begin
            tick();
            start_i = 1'b0;
            abort_i = 1'b0;
            #1;
            got = {ready_o, rst_cnt_o, valid_o, load_o, done_o};
            exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL abort_idle_start c=%0d got %b exp %b", c, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [14:0] got, exp;
        sew_i = 2'b10; elem_cnt_i = 6'd8; dir_i = 1'b1;
        slide_offset_i = 9'h0F3; start_i = 1'b1; ready_i = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            start_i = 1'b0;
        end
        #1;
        checks++;
        if (valid_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre got valid %b exp 1", valid_o);
        end
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        #1;
        got = {ready_o, load_o, rst_cnt_o, en_o, secondary_en_o, valid_o, last_o,
               done_o, error_o, up_down_o, element_width_o, slide_offset_o[2:0]};
        exp = {1'b1, 1'b0, 1'b0, 1'b0, SEC_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL rst_mid_outputs got %b exp %b", got, exp);
        end
        checks++;
        if (slide_offset_o !== '0) begin
            errors++;
            $display("FAIL rst_mid_offset got %h exp 0", slide_offset_o);
        end
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++;
            if (done_o !== 1'b0 || ready_o !== 1'b1) begin
                errors++;
                $display("FAIL rst_mid_after c=%0d got done %b ready %b exp 0 1", c, done_o, ready_o);
            end
        end
    endtask

    task automatic test_busy_start();
        logic [4:0]  got, exp;
        logic [11:0] gl, el;
        sew_i = 2'b10; elem_cnt_i = 6'd4; dir_i = 1'b0;
        slide_offset_i = 9'h033; start_i = 1'b1; ready_i = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            start_i = (c == 3);
            if (c == 3) begin
                sew_i = 2'b00; dir_i = 1'b1; slide_offset_i = 9'h1FF; elem_cnt_i = 6'd20;
            end
            #1;
            got = {ready_o, load_o, valid_o, last_o, done_o};
            exp = {c >= 7, c == 1, (c >= 2 && c <= 5), c == 5, c == 6};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL busy_seq c=%0d got %b exp %b", c, got, exp);
            end
            gl = {up_down_o, element_width_o, slide_offset_o};
            el = {1'b0, 2'b10, 9'h033};
            checks++;
            if (gl !== el) begin
                errors++;
                $display("FAIL busy_latched c=%0d got %h exp %h", c, gl, el);
            end
        end
        start_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_word_no_stall();
`ifdef VRF_ADDR_SEQ_STALL_EN
        test_byte_stall();
`else
        test_no_stall_macro();
`endif
        test_illegal_zero();
        test_abort();
        test_reset_mid_run();
        test_busy_start();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
